// File: rtl/mod_arith_unit.sv
// Modular arithmetic unit: (a+b) mod m, (a-b) mod m and (a*b) mod m.
// Multiplication is MSB-first interleaved, one multiplier bit per cycle.
module mod_arith_unit #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             load;
  logic             chk_err;

  logic [W1-1:0]    sum, diff;
  logic [WIDTH-1:0] add_res, sub_res;
  logic [W2-1:0]    dbl, red1, addv, red2;
  logic [WIDTH-1:0] acc_nxt;

  assign load    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign chk_err = (m_q == '0) || (a_q >= m_q) || (b_q >= m_q) || (op_q == OP_RSV);

  // Single-cycle add/sub and one interleaved-multiply step
  always_comb begin
    sum     = W1'(a_q) + W1'(b_q);
    add_res = (sum >= W1'(m_q)) ? WIDTH'(sum - W1'(m_q)) : WIDTH'(sum);
    diff    = W1'(a_q) - W1'(b_q);
    sub_res = (a_q >= b_q) ? WIDTH'(diff) : WIDTH'(diff + W1'(m_q));

    dbl     = W2'(acc_q) << 1;
    red1    = (dbl >= W2'(m_q)) ? (dbl - W2'(m_q)) : dbl;
    addv    = red1 + W2'(a_q);
    red2    = (addv >= W2'(m_q)) ? (addv - W2'(m_q)) : addv;
    acc_nxt = b_q[cnt_q] ? WIDTH'(red2) : WIDTH'(red1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = chk_err ? S_DONE : S_EXEC;
      S_EXEC:  if ((op_q != OP_MUL) || (cnt_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = start ? S_CHECK : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with it
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = (state_d == S_CHECK) || (state_d == S_EXEC);
    done_d   = (state_d == S_DONE);
    err_d    = (state_q == S_CHECK) && chk_err;

    if (load) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      m_d   = m;
      acc_d = '0;
      cnt_d = CW'(WIDTH - 1);
    end

    case (state_q)
      S_CHECK: if (chk_err) result_d = '0;
      S_EXEC: begin
        case (op_q)
          OP_ADD: result_d = add_res;
          OP_SUB: result_d = sub_res;
          default: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) result_d = acc_nxt;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_arith_unit.sv
// Bench for mod_arith_unit: an 8-bit and a 256-bit instance checked against
// plain modular arithmetic (+, -, *, %) on wide integers.
module tb_mod_arith_unit;

  localparam int unsigned WS = 8;
  localparam int unsigned WL = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          s_start, s_busy, s_done, s_err;
  logic [1:0]    s_op;
  logic [WS-1:0] s_a, s_b, s_m, s_res;
  logic          l_start, l_busy, l_done, l_err;
  logic [1:0]    l_op;
  logic [WL-1:0] l_a, l_b, l_m, l_res;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [WL-1:0] P256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  mod_arith_unit #(.WIDTH(WS)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op),
    .a(s_a), .b(s_b), .m(s_m),
    .result(s_res), .busy(s_busy), .done(s_done), .err(s_err)
  );

  mod_arith_unit #(.WIDTH(WL)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(l_start), .op(l_op),
    .a(l_a), .b(l_b), .m(l_m),
    .result(l_res), .busy(l_busy), .done(l_done), .err(l_err)
  );

  // Reference: {err, result} from the arithmetic definition
  function automatic logic [WS:0] ref_s(input logic [1:0] op, input logic [WS-1:0] a, b, m);
    int ia, ib, im, r;
    ia = int'(a); ib = int'(b); im = int'(m);
    if (im == 0 || ia >= im || ib >= im || op == 2'b11) return {1'b1, WS'(0)};
    case (op)
      2'b00:   r = (ia + ib) % im;
      2'b01:   r = (ia - ib + im) % im;
      default: r = (ia * ib) % im;
    endcase
    return {1'b0, WS'(r)};
  endfunction

  function automatic logic [WL:0] ref_l(input logic [1:0] op, input logic [WL-1:0] a, b, m);
    logic [2*WL-1:0] wa, wb, wm, r;
    wa = (2*WL)'(a); wb = (2*WL)'(b); wm = (2*WL)'(m);
    if (m == '0 || a >= m || b >= m || op == 2'b11) return {1'b1, WL'(0)};
    case (op)
      2'b00:   r = (wa + wb) % wm;
      2'b01:   r = (wa + wm - wb) % wm;
      default: r = (wa * wb) % wm;
    endcase
    return {1'b0, WL'(r)};
  endfunction

  function automatic int exp_lat(input int w, input logic err, input logic [1:0] op);
    if (err) return 1;
    if (op == 2'b10) return w + 1;
    return 2;
  endfunction

  function automatic logic [WL-1:0] rand_l();
    logic [WL-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drivers: called just after a falling edge; return just after the falling
  // edge on which done is seen, with edges-since-start and busy-cycle count.
  task automatic run_s(input logic [1:0] op, input logic [WS-1:0] a, b, m, input int glitch_at,
                       output logic [WS-1:0] res, output logic er, output int lat, output int bcnt);
    bit tmo;
    s_op = op; s_a = a; s_b = b; s_m = m; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0; bcnt = 0; tmo = 1'b1;
    while (lat <= int'(WS) + 8) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_done) begin tmo = 1'b0; break; end
      if (s_busy) bcnt++;
      if (lat == glitch_at) begin
        s_start = 1'b1; s_op = 2'($urandom);
        s_a = WS'($urandom); s_b = WS'($urandom); s_m = WS'($urandom);
      end
      @(posedge clk);
      lat++;
    end
    if (tmo) @(negedge clk);
    res = s_res; er = s_err;
  endtask

  task automatic run_l(input logic [1:0] op, input logic [WL-1:0] a, b, m,
                       output logic [WL-1:0] res, output logic er, output int lat, output int bcnt);
    bit tmo;
    l_op = op; l_a = a; l_b = b; l_m = m; l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    lat = 0; bcnt = 0; tmo = 1'b1;
    while (lat <= int'(WL) + 8) begin
      @(negedge clk);
      if (l_done) begin tmo = 1'b0; break; end
      if (l_busy) bcnt++;
      @(posedge clk);
      lat++;
    end
    if (tmo) @(negedge clk);
    res = l_res; er = l_err;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({s_busy, s_done, s_err, s_res} !== '0) begin
      miscompares++; $display("FAIL reset_s: got b%0b d%0b e%0b r%0h want all 0", s_busy, s_done, s_err, s_res);
    end
    vectors++;
    if ({l_busy, l_done, l_err, l_res} !== '0) begin
      miscompares++; $display("FAIL reset_l: got b%0b d%0b e%0b r%0h want all 0", l_busy, l_done, l_err, l_res);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({s_busy, s_done, l_busy, l_done} !== 4'b0) begin
      miscompares++; $display("FAIL idle_after_reset: got %b want 0000", {s_busy, s_done, l_busy, l_done});
    end
  endtask

  task automatic test_add8();
    logic [WS-1:0] r; logic e; int lat, bc;
    run_s(2'b00, 8'd200, 8'd100, 8'd251, -1, r, e, lat, bc);
    vectors++; if (r !== 8'd49) begin miscompares++; $display("FAIL add8 result: got %0d want 49", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL add8 err: got %b want 0", e); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL add8 latency: got %0d want 2", lat); end
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL add8 busy_at_done: got %b want 0", s_busy); end
    @(negedge clk);
    vectors++; if (s_done !== 1'b0) begin miscompares++; $display("FAIL add8 done_pulse: got %b want 0", s_done); end
  endtask

  task automatic test_sub_mul8();
    logic [WS-1:0] r; logic e; int lat, bc;
    run_s(2'b01, 8'd100, 8'd200, 8'd251, -1, r, e, lat, bc);
    vectors++; if (r !== 8'd151) begin miscompares++; $display("FAIL sub8 result: got %0d want 151", r); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL sub8 latency: got %0d want 2", lat); end
    @(negedge clk);
    run_s(2'b10, 8'd200, 8'd100, 8'd251, -1, r, e, lat, bc);
    vectors++; if (r !== 8'd171) begin miscompares++; $display("FAIL mul8 result: got %0d want 171", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL mul8 err: got %b want 0", e); end
    vectors++; if (lat != 9) begin miscompares++; $display("FAIL mul8 latency: got %0d want 9", lat); end
    vectors++; if (bc != 9) begin miscompares++; $display("FAIL mul8 busy_cycles: got %0d want 9", bc); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [1:0] ops [3] = '{2'b00, 2'b10, 2'b11};
    logic [WS-1:0] as [3] = '{8'd251, 8'd5, 8'd5};
    logic [WS-1:0] ms [3] = '{8'd251, 8'd0, 8'd251};
    logic [WS-1:0] r; logic e; int lat, bc;
    logic [WL-1:0] rl;
    for (int i = 0; i < 3; i++) begin
      run_s(ops[i], as[i], 8'd3, ms[i], -1, r, e, lat, bc);
      vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL err%0d flag: got %b want 1", i, e); end
      vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL err%0d result: got %0d want 0", i, r); end
      vectors++; if (lat != 1) begin miscompares++; $display("FAIL err%0d latency: got %0d want 1", i, lat); end
      vectors++; if (bc != 1) begin miscompares++; $display("FAIL err%0d busy_cycles: got %0d want 1", i, bc); end
      @(negedge clk);
      vectors++; if (s_err !== 1'b0) begin miscompares++; $display("FAIL err%0d err_after_done: got %b want 0", i, s_err); end
    end
    run_l(2'b10, P256, 256'd1, P256, rl, e, lat, bc);
    vectors++; if ({e, rl} !== {1'b1, WL'(0)}) begin miscompares++; $display("FAIL err256: got e%b r%0h want e1 r0", e, rl); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL err256 latency: got %0d want 1", lat); end
    @(negedge clk);
  endtask

  task automatic test_mul256();
    logic [WL-1:0] r; logic e; int lat, bc;
    run_l(2'b10, P256 - WL'(1), P256 - WL'(1), P256, r, e, lat, bc);
    vectors++; if (r !== WL'(1)) begin miscompares++; $display("FAIL mul256 result: got %0h want 1", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL mul256 err: got %b want 0", e); end
    vectors++; if (lat != 257) begin miscompares++; $display("FAIL mul256 latency: got %0d want 257", lat); end
    vectors++; if (bc != 257) begin miscompares++; $display("FAIL mul256 busy_cycles: got %0d want 257", bc); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    logic [WS-1:0] r; logic e; int lat, bc;
    for (int g = 0; g < 8; g++) begin
      run_s(2'b10, 8'd123, 8'd77, 8'd239, g, r, e, lat, bc);
      vectors++; if (r !== 8'd150) begin miscompares++; $display("FAIL ignore_start g%0d result: got %0d want 150", g, r); end
      vectors++; if (lat != 9) begin miscompares++; $display("FAIL ignore_start g%0d latency: got %0d want 9", g, lat); end
      @(negedge clk);
    end
    run_s(2'b00, 8'd10, 8'd20, 8'd29, 0, r, e, lat, bc);
    vectors++; if (r !== 8'd1) begin miscompares++; $display("FAIL ignore_start add result: got %0d want 1", r); end
    @(negedge clk);
  endtask

  // Second start is raised on the DONE cycle of the first operation
  task automatic test_back_to_back();
    logic [WS-1:0] r; logic e; int lat, bc;
    logic [WL-1:0] rl, xa, xb; logic [WL:0] ex;
    run_s(2'b10, 8'd200, 8'd100, 8'd251, -1, r, e, lat, bc);
    vectors++; if (r !== 8'd171) begin miscompares++; $display("FAIL b2b first result: got %0d want 171", r); end
    run_s(2'b01, 8'd3, 8'd9, 8'd11, -1, r, e, lat, bc);
    vectors++; if (r !== 8'd5) begin miscompares++; $display("FAIL b2b second result: got %0d want 5", r); end
    vectors++; if (lat != 2 || bc != 2) begin miscompares++; $display("FAIL b2b second timing: got lat %0d busy %0d want 2 2", lat, bc); end
    xa = rand_l() % P256; xb = rand_l() % P256;
    run_l(2'b00, xa, xb, P256, rl, e, lat, bc);
    ex = ref_l(2'b00, xa, xb, P256);
    vectors++; if (rl !== ex[WL-1:0]) begin miscompares++; $display("FAIL b2b256 first: got %0h want %0h", rl, ex[WL-1:0]); end
    run_l(2'b10, xa, xb, P256, rl, e, lat, bc);
    ex = ref_l(2'b10, xa, xb, P256);
    vectors++; if (rl !== ex[WL-1:0]) begin miscompares++; $display("FAIL b2b256 second: got %0h want %0h", rl, ex[WL-1:0]); end
    vectors++; if (bc != 257) begin miscompares++; $display("FAIL b2b256 busy_cycles: got %0d want 257", bc); end
    @(negedge clk);
  endtask

  task automatic test_random8();
    logic [1:0] op; logic [WS-1:0] a, b, m, r; logic e; int lat, bc, el;
    logic [WS:0] ex;
    for (int n = 0; n < 150; n++) begin
      m  = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      a  = (m == 0 || $urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom % int'(m));
      b  = (m == 0 || $urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom % int'(m));
      op = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_s(op, a, b, m, -1, r, e, lat, bc);
      ex = ref_s(op, a, b, m);
      el = exp_lat(int'(WS), ex[WS], op);
      vectors++; if (r !== ex[WS-1:0]) begin miscompares++; $display("FAIL rnd8 result op%0d %0d,%0d mod %0d: got %0d want %0d", op, a, b, m, r, ex[WS-1:0]); end
      vectors++; if (e !== ex[WS]) begin miscompares++; $display("FAIL rnd8 err op%0d %0d,%0d mod %0d: got %b want %b", op, a, b, m, e, ex[WS]); end
      vectors++; if (lat != el || bc != el) begin miscompares++; $display("FAIL rnd8 timing op%0d: got lat %0d busy %0d want %0d", op, lat, bc, el); end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_random256();
    logic [1:0] op; logic [WL-1:0] a, b, m, r; logic e; int lat, bc, el;
    logic [WL:0] ex;
    for (int n = 0; n < 8; n++) begin
      m  = rand_l() | (WL'(1) << (WL - 1));
      a  = rand_l() % m;
      b  = rand_l() % m;
      op = 2'(n % 3);
      run_l(op, a, b, m, r, e, lat, bc);
      ex = ref_l(op, a, b, m);
      el = exp_lat(int'(WL), ex[WL], op);
      vectors++; if ({e, r} !== ex) begin miscompares++; $display("FAIL rnd256 op%0d: got e%b r%0h want e%b r%0h", op, e, r, ex[WL], ex[WL-1:0]); end
      vectors++; if (lat != el) begin miscompares++; $display("FAIL rnd256 latency op%0d: got %0d want %0d", op, lat, el); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    logic [WL-1:0] r; logic e; int lat, bc;
    l_op = 2'b10; l_a = P256 - WL'(5); l_b = P256 - WL'(7); l_m = P256; l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    vectors++; if (l_busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid busy_before: got %b want 1", l_busy); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({l_busy, l_done, l_err, l_res} !== '0) begin
      miscompares++; $display("FAIL rst_mid async_l: got b%0b d%0b e%0b r%0h want all 0", l_busy, l_done, l_err, l_res);
    end
    vectors++;
    if ({s_busy, s_done, s_err, s_res} !== '0) begin
      miscompares++; $display("FAIL rst_mid async_s: got b%0b d%0b e%0b r%0h want all 0", s_busy, s_done, s_err, s_res);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_l(2'b00, WL'(17), WL'(30), WL'(41), r, e, lat, bc);
    vectors++; if (r !== WL'(6)) begin miscompares++; $display("FAIL rst_mid add result: got %0h want 6", r); end
    vectors++; if (lat != 2 || bc != 2) begin miscompares++; $display("FAIL rst_mid add timing: got lat %0d busy %0d want 2 2", lat, bc); end
    @(negedge clk);
    vectors++; if (l_done !== 1'b0) begin miscompares++; $display("FAIL rst_mid stale_done: got %b want 0", l_done); end
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0; s_m = '0;
    l_start = 1'b0; l_op = '0; l_a = '0; l_b = '0; l_m = '0;
    test_reset();
    test_add8();
    test_sub_mul8();
    test_errors();
    test_mul256();
    test_ignored_start();
    test_back_to_back();
    test_random8();
    test_random256();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
